flit_operand_injector: RTL and testbench
========================================

// Module: flit_operand_injector
// PURPOSE
//   Packetised operand source sitting directly upstream of the adder characterization stage.
//   Emits packets of PAYLOAD flits, then GAP idle cycles, for NUM_PACKETS packets.
//   Each flit is a 2N-bit thermometer word split into the two adder operands.
//   Link utilisation and switching activity are therefore set by parameters, not by bench code.
// PARAMETERS
//   N           21  operand width; the flit word is 2N bits
//   PAYLOAD     20  flits per packet (>=1)
//   GAP          7  idle cycles after every packet (>=0)
//   NUM_PACKETS 10  packets per run (>=1)
//   STRIDE      11  thermometer-length increment per flit (1..2N)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   1-cycle pulse; begins a run from IDLE or DONE, ignored otherwise
//   out_ready  in   1   downstream accepts a flit this cycle
//   out_valid  out  1   input1/input2 carry a valid flit
//   input1     out  N   flit word [N-1:0], feeds adder input1
//   input2     out  N   flit word [2N-1:N], feeds adder input2
//   busy       out  1   high in SEND or GAP
//   done       out  1   level; high in DONE
//   flit_cnt   out  $clog2(PAYLOAD+1)  flits accepted in the current packet
//   pkt_cnt    out  16  packets fully sent in the current run
// BEHAVIOUR
//   - Reset: all outputs are 0; state=IDLE; len=0; side=MSB. rst overrides start and is honoured mid-run.
//   - All outputs are registered.
//   - FSM states: IDLE, SEND, GAP, DONE.
//     IDLE/DONE --start--> SEND: in the next cycle, out_valid=1 and flit 0 is presented; pkt_cnt=0 and done=0.
//     SEND: a flit is accepted when out_valid & out_ready. After accept number PAYLOAD, enter GAP, or go
//       straight to the next packet's SEND when GAP==0. pkt_cnt increments on that final accept.
//     GAP: out_valid=0 for exactly GAP cycles. Then go to SEND if pkt_cnt<NUM_PACKETS, otherwise DONE.
//       The final packet is also followed by GAP.
//     DONE: out_valid=0 and done=1 until start or rst.
//   - Handshake: while out_valid & ~out_ready, input1, input2 and flit_cnt hold stable. out_valid is never
//     dropped mid-packet.
//   - In GAP and DONE, input1/input2 hold the last flit, so the adder sees no toggles.
//   - Pattern state (len, side) is reset at each packet start to len=STRIDE, side=MSB.
//     word = side==MSB ? ~((1<<(2N-len))-1) : ((1<<len)-1), 2N bits wide.
//   - After each accept: side toggles; len_next = len+STRIDE, minus (2N+1) if the sum exceeds 2N.
//     Compute len_next at $clog2(4N+2) width, with no overflow.
//   - flit_cnt clears at packet start and counts accepts 0..PAYLOAD.
//   - start while busy is ignored. start and rst together: rst wins.
//   - Timing, with out_ready tied high: start sampled at cycle 0.
//     Packet k spans cycles 1+(PAYLOAD+GAP)*(k-1) .. +PAYLOAD-1.
//     done=1 from cycle (PAYLOAD+GAP)*NUM_PACKETS+1.
// STRUCTURE
//   - Shared package injector_pkg: state enum {IDLE,SEND,GAP,DONE}; width functions for the len,
//     flit_cnt and gap counters.
//   - Sub-module thermo_word_gen: combinational, (len, side) -> 2N-bit word. The top level holds the FSM,
//     counters and output registers.
// TESTING
//   1. rst high for 3 cycles -> all outputs 0, state IDLE. start while rst high -> no effect.
//   2. Defaults, start at cycle 0, out_ready=1:
//      - cycle 1: input2=21'h1FFC00, input1=0
//      - cycle 2: input1=21'h1FFFFF, input2=21'h000001
//      - cycle 4 (len wrap to 1): input1=21'h000001, input2=0
//   3. Gap timing -> out_valid high cycles 1-20, low 21-27, high from 28. pkt_cnt=1 at cycle 21.
//      done=1 at cycle 271, and out_valid never high after 263.
//   4. Backpressure: out_ready=0 for cycles 5-8 -> input1/input2/flit_cnt frozen. Packet ends 4 cycles later.
//      Flit sequence is unchanged.
//   5. rst asserted mid-packet (flit_cnt=9) -> next cycle all outputs 0, IDLE. A fresh start repeats test 2.
//   6. GAP=0, PAYLOAD=1 -> out_valid continuously high for NUM_PACKETS cycles; every flit equals flit 0.
//      Restart from DONE clears done.

Source files
------------

// File: rtl/injector_pkg.sv
// Shared types and width helpers for the packetised thermometer operand injector.
package injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Which end of the 2N-bit word the thermometer run is anchored to.
  typedef enum logic {
    SIDE_LSB = 1'b0,
    SIDE_MSB = 1'b1
  } side_t;

  // len + STRIDE can reach 4N before the wrap is subtracted.
  function automatic int len_w(input int n);
    return $clog2(4 * n + 2);
  endfunction

  function automatic int cnt_w(input int payload);
    return $clog2(payload + 1);
  endfunction

  // Gap counter runs 0..GAP-1; keep at least one bit when GAP is 0 or 1.
  function automatic int gap_w(input int gap);
    return (gap < 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/thermo_word_gen.sv
// Combinational thermometer word: len ones anchored at the MSB or LSB end of a 2N-bit word.
module thermo_word_gen
  import injector_pkg::*;
#(
  parameter int N     = 21,
  parameter int LEN_W = 7
) (
  input  logic [LEN_W-1:0] len,
  input  side_t            side,
  output logic [2*N-1:0]   word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (side == SIDE_MSB) word[i] = (i >= 2 * N - int'(len));
      else                  word[i] = (i < int'(len));
    end
  end

endmodule

// File: rtl/flit_operand_injector.sv
// Packetised operand source: PAYLOAD thermometer flits per packet, GAP idle cycles after each,
// NUM_PACKETS packets per run, with valid/ready backpressure and fully registered outputs.
module flit_operand_injector
  import injector_pkg::*;
#(
  parameter int N           = 21,
  parameter int PAYLOAD     = 20,
  parameter int GAP         = 7,
  parameter int NUM_PACKETS = 10,
  parameter int STRIDE      = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [N-1:0]                 input1,
  output logic [N-1:0]                 input2,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(PAYLOAD+1)-1:0] flit_cnt,
  output logic [15:0]                  pkt_cnt
);

  localparam int W2    = 2 * N;
  localparam int LEN_W = len_w(N);
  localparam int FC_W  = cnt_w(PAYLOAD);
  localparam int GC_W  = gap_w(GAP);

  localparam logic [LEN_W-1:0] STRIDE_L  = LEN_W'(STRIDE);
  localparam logic [LEN_W-1:0] TWO_N_L   = LEN_W'(W2);
  localparam logic [LEN_W-1:0] WRAP_L    = LEN_W'(W2 + 1);
  localparam logic [FC_W-1:0]  FLIT_LAST = FC_W'(PAYLOAD - 1);
  localparam logic [15:0]      PKT_LAST  = 16'(NUM_PACKETS - 1);
  localparam logic [15:0]      PKT_TOTAL = 16'(NUM_PACKETS);
  localparam logic [GC_W-1:0]  GAP_LAST  = GC_W'((GAP > 0) ? GAP - 1 : 0);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len, len_nxt, len_sum, len_adv, gen_len;
  side_t             side, side_nxt, gen_side;
  logic [W2-1:0]     word;
  logic [FC_W-1:0]   flit_nxt;
  logic [15:0]       pkt_nxt;
  logic [GC_W-1:0]   gap_cnt, gap_nxt;
  logic              valid_nxt;
  logic              load_word;

  always_comb begin
    len_sum = len + STRIDE_L;
    len_adv = (len_sum > TWO_N_L) ? len_sum - WRAP_L : len_sum;
  end

  // Next-state and next-register values; gen_len/gen_side select which flit is loaded.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    side_nxt  = side;
    flit_nxt  = flit_cnt;
    pkt_nxt   = pkt_cnt;
    gap_nxt   = gap_cnt;
    valid_nxt = out_valid;
    load_word = 1'b0;
    gen_len   = len_adv;
    gen_side  = (side == SIDE_MSB) ? SIDE_LSB : SIDE_MSB;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SEND;
          valid_nxt = 1'b1;
          flit_nxt  = '0;
          pkt_nxt   = '0;
          gen_len   = STRIDE_L;
          gen_side  = SIDE_MSB;
          load_word = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_valid && out_ready) begin
          if (flit_cnt == FLIT_LAST) begin
            pkt_nxt = pkt_cnt + 16'd1;
            if (GAP > 0) begin
              state_nxt = ST_GAP;
              valid_nxt = 1'b0;
              flit_nxt  = flit_cnt + 1'b1;
              gap_nxt   = '0;
            end else if (pkt_cnt == PKT_LAST) begin
              state_nxt = ST_DONE;
              valid_nxt = 1'b0;
              flit_nxt  = flit_cnt + 1'b1;
            end else begin
              flit_nxt  = '0;
              gen_len   = STRIDE_L;
              gen_side  = SIDE_MSB;
              load_word = 1'b1;
            end
          end else begin
            flit_nxt  = flit_cnt + 1'b1;
            load_word = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (pkt_cnt < PKT_TOTAL) begin
            state_nxt = ST_SEND;
            valid_nxt = 1'b1;
            flit_nxt  = '0;
            gen_len   = STRIDE_L;
            gen_side  = SIDE_MSB;
            load_word = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load_word) begin
      len_nxt  = gen_len;
      side_nxt = gen_side;
    end
  end

  thermo_word_gen #(.N(N), .LEN_W(LEN_W)) u_gen (
    .len  (gen_len),
    .side (gen_side),
    .word (word)
  );

  // Output register stage; words only change when a new flit is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      side      <= SIDE_MSB;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      input1    <= '0;
      input2    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flit_cnt  <= '0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      side      <= side_nxt;
      gap_cnt   <= gap_nxt;
      out_valid <= valid_nxt;
      busy      <= (state_nxt == ST_SEND) || (state_nxt == ST_GAP);
      done      <= (state_nxt == ST_DONE);
      flit_cnt  <= flit_nxt;
      pkt_cnt   <= pkt_nxt;
      if (load_word) begin
        input1 <= word[N-1:0];
        input2 <= word[W2-1:N];
      end
    end
  end

endmodule

// File: tb/tb_flit_operand_injector.sv
// Bench for flit_operand_injector: default configuration plus a PAYLOAD=1, GAP=0 instance.
module tb_flit_operand_injector;

  localparam int N  = 21;
  localparam int W2 = 2 * N;
  localparam int P  = 20;
  localparam int G  = 7;
  localparam int NP = 10;
  localparam int S  = 11;
  localparam int PERIOD = P + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, ready_a = 1'b1;
  logic start_b = 1'b0, ready_b = 1'b1;

  logic          valid_a, busy_a, done_a;
  logic [N-1:0]  in1_a, in2_a;
  logic [4:0]    fc_a;
  logic [15:0]   pc_a;
  logic          valid_b, busy_b, done_b;
  logic [N-1:0]  in1_b, in2_b;
  logic [0:0]    fc_b;
  logic [15:0]   pc_b;
  logic [W2-1:0] got_a, got_b;

  int n_chk  = 0;
  int n_fail = 0;

  assign got_a = {in2_a, in1_a};
  assign got_b = {in2_b, in1_b};

  always #5 clk = ~clk;

  flit_operand_injector #(.N(N), .PAYLOAD(P), .GAP(G), .NUM_PACKETS(NP), .STRIDE(S)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .out_ready(ready_a), .out_valid(valid_a),
    .input1(in1_a), .input2(in2_a), .busy(busy_a), .done(done_a), .flit_cnt(fc_a), .pkt_cnt(pc_a)
  );

  flit_operand_injector #(.N(N), .PAYLOAD(1), .GAP(0), .NUM_PACKETS(NP), .STRIDE(S)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .out_ready(ready_b), .out_valid(valid_b),
    .input1(in1_b), .input2(in2_b), .busy(busy_b), .done(done_b), .flit_cnt(fc_b), .pkt_cnt(pc_b)
  );

  // Flit k of a packet: run length (k+1)*STRIDE mod (2N+1), alternating MSB/LSB anchoring.
  function automatic logic [W2-1:0] exp_word(input int k);
    int len;
    logic [63:0] w;
    len = ((k + 1) * S) % (W2 + 1);
    if (k % 2 == 0) w = ~((64'd1 << (W2 - len)) - 64'd1);
    else            w = (64'd1 << len) - 64'd1;
    return w[W2-1:0];
  endfunction

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({valid_a, busy_a, done_a, fc_a, pc_a, got_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got v=%b b=%b d=%b fc=%0d pc=%0d w=%h, expected all zero",
               valid_a, busy_a, done_a, fc_a, pc_a, got_a);
    end
    n_chk++;
    if ({valid_b, busy_b, done_b, fc_b, pc_b, got_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got v=%b d=%b pc=%0d w=%h, expected all zero",
               valid_b, done_b, pc_b, got_b);
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    n_chk++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_under_reset: got valid=%b busy=%b, expected 0 0", valid_a, busy_a);
    end
  endtask

  task automatic test_pattern_timing();
    bit ev, eb, ed;
    int idx, pos, efc, epc, eflit;
    ready_a = 1'b1;
    pulse_start_a();
    for (int c = 1; c <= PERIOD * NP + 5; c++) begin
      if (c <= PERIOD * NP) begin
        idx = c - 1; pos = idx % PERIOD;
        ev = (pos < P); eb = 1'b1; ed = 1'b0;
        efc = ev ? pos : P;
        epc = idx / PERIOD + (ev ? 0 : 1);
        eflit = ev ? pos : P - 1;
      end else begin
        ev = 1'b0; eb = 1'b0; ed = 1'b1; efc = P; epc = NP; eflit = P - 1;
      end
      n_chk++;
      if (valid_a !== ev) begin n_fail++; $display("FAIL timing_valid c=%0d: got %b expected %b", c, valid_a, ev); end
      n_chk++;
      if (busy_a !== eb) begin n_fail++; $display("FAIL timing_busy c=%0d: got %b expected %b", c, busy_a, eb); end
      n_chk++;
      if (done_a !== ed) begin n_fail++; $display("FAIL timing_done c=%0d: got %b expected %b", c, done_a, ed); end
      n_chk++;
      if (fc_a !== 5'(efc)) begin n_fail++; $display("FAIL timing_flit_cnt c=%0d: got %0d expected %0d", c, fc_a, efc); end
      n_chk++;
      if (pc_a !== 16'(epc)) begin n_fail++; $display("FAIL timing_pkt_cnt c=%0d: got %0d expected %0d", c, pc_a, epc); end
      n_chk++;
      if (got_a !== exp_word(eflit)) begin
        n_fail++; $display("FAIL timing_word c=%0d: got %h expected %h", c, got_a, exp_word(eflit));
      end
      if (c == 1 || c == 2 || c == 4) begin
        n_chk++;
        if ((c == 1 && (in2_a !== 21'h1FFC00 || in1_a !== 21'h0)) ||
            (c == 2 && (in2_a !== 21'h000001 || in1_a !== 21'h1FFFFF)) ||
            (c == 4 && (in2_a !== 21'h0 || in1_a !== 21'h000001))) begin
          n_fail++; $display("FAIL known_vector c=%0d: got in2=%h in1=%h", c, in2_a, in1_a);
        end
      end
      start_a = (c == 100);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic test_backpressure(input int s, input int l);
    int stalls, cp, efc, epc, eflit;
    bit ev;
    ready_a = 1'b1;
    pulse_start_a();
    for (int c = 1; c <= PERIOD + l; c++) begin
      stalls = (c - s < 0) ? 0 : ((c - s > l) ? l : c - s);
      cp = c - stalls;
      ev = (cp <= P);
      efc = ev ? cp - 1 : P;
      epc = ev ? 0 : 1;
      eflit = ev ? cp - 1 : P - 1;
      n_chk++;
      if (valid_a !== ev) begin n_fail++; $display("FAIL bp_valid s=%0d c=%0d: got %b expected %b", s, c, valid_a, ev); end
      n_chk++;
      if (fc_a !== 5'(efc)) begin n_fail++; $display("FAIL bp_flit_cnt s=%0d c=%0d: got %0d expected %0d", s, c, fc_a, efc); end
      n_chk++;
      if (pc_a !== 16'(epc)) begin n_fail++; $display("FAIL bp_pkt_cnt s=%0d c=%0d: got %0d expected %0d", s, c, pc_a, epc); end
      n_chk++;
      if (got_a !== exp_word(eflit)) begin
        n_fail++; $display("FAIL bp_word s=%0d c=%0d: got %h expected %h", s, c, got_a, exp_word(eflit));
      end
      ready_a = !(c >= s && c < s + l);
      @(negedge clk);
    end
    ready_a = 1'b1;
    reset_pulse();
  endtask

  task automatic test_mid_reset();
    ready_a = 1'b1;
    pulse_start_a();
    repeat (9) @(negedge clk);
    n_chk++;
    if (fc_a !== 5'd9) begin n_fail++; $display("FAIL midrst_pre_flit_cnt: got %0d expected 9", fc_a); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({valid_a, busy_a, done_a, fc_a, pc_a, got_a} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got v=%b b=%b d=%b fc=%0d pc=%0d w=%h, expected all zero",
               valid_a, busy_a, done_a, fc_a, pc_a, got_a);
    end
    start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    @(negedge clk);
    n_chk++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: got valid=%b busy=%b expected 0 0", valid_a, busy_a);
    end
    pulse_start_a();
    for (int c = 1; c <= 4; c++) begin
      n_chk++;
      if (got_a !== exp_word(c - 1) || valid_a !== 1'b1) begin
        n_fail++; $display("FAIL midrst_restart c=%0d: got v=%b w=%h expected v=1 w=%h", c, valid_a, got_a, exp_word(c - 1));
      end
      @(negedge clk);
    end
    reset_pulse();
  endtask

  task automatic test_random_ready();
    int acc = 0, gap_left = 0;
    bit ev, ed, r, finished = 1'b0;
    pulse_start_a();
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      ev = (gap_left == 0 && acc < P * NP);
      ed = (gap_left == 0 && acc == P * NP);
      n_chk++;
      if (valid_a !== ev) begin n_fail++; $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, valid_a, ev); end
      n_chk++;
      if (done_a !== ed) begin n_fail++; $display("FAIL rand_done cyc=%0d: got %b expected %b", cyc, done_a, ed); end
      if (ev) begin
        n_chk++;
        if (got_a !== exp_word(acc % P) || fc_a !== 5'(acc % P)) begin
          n_fail++;
          $display("FAIL rand_flit cyc=%0d: got w=%h fc=%0d expected w=%h fc=%0d",
                   cyc, got_a, fc_a, exp_word(acc % P), acc % P);
        end
      end
      if (ed) finished = 1'b1;
      r = ($urandom % 4) != 0;
      ready_a = r;
      if (gap_left > 0) gap_left--;
      else if (ev && r) begin
        acc++;
        if (acc % P == 0) gap_left = G;
      end
      @(negedge clk);
    end
    ready_a = 1'b1;
    n_chk++;
    if (!finished) begin n_fail++; $display("FAIL rand_timeout: got accepts=%0d expected %0d", acc, P * NP); end
    n_chk++;
    if (pc_a !== 16'(NP)) begin n_fail++; $display("FAIL rand_pkt_cnt: got %0d expected %0d", pc_a, NP); end
  endtask

  task automatic test_single_flit_no_gap();
    int epc;
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      epc = (c - 1 > NP) ? NP : c - 1;
      n_chk++;
      if (valid_b !== (c <= NP) || busy_b !== (c <= NP) || done_b !== (c > NP)) begin
        n_fail++; $display("FAIL b_ctrl c=%0d: got v=%b b=%b d=%b", c, valid_b, busy_b, done_b);
      end
      n_chk++;
      if (got_b !== exp_word(0)) begin n_fail++; $display("FAIL b_word c=%0d: got %h expected %h", c, got_b, exp_word(0)); end
      n_chk++;
      if (pc_b !== 16'(epc)) begin n_fail++; $display("FAIL b_pkt_cnt c=%0d: got %0d expected %0d", c, pc_b, epc); end
      @(negedge clk);
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n_chk++;
    if (done_b !== 1'b0 || valid_b !== 1'b1 || pc_b !== 16'd0) begin
      n_fail++; $display("FAIL b_restart: got d=%b v=%b pc=%0d expected 0 1 0", done_b, valid_b, pc_b);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_timing();
    test_backpressure(5, 4);
    test_backpressure(2 + int'($urandom_range(10)), 1 + int'($urandom_range(5)));
    test_mid_reset();
    test_random_ready();
    test_single_flit_no_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
